// File: rtl/row_strobe_gen.sv
// Sequenced 1-of-12 row-strobe generator: takes a binary row code over valid/ready
// and drives the matching one-hot row bit for PULSE_W clocks, then idles for GAP_W clocks.
module row_strobe_gen #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [3:0]  i_code,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_clear,
  output logic [11:0] o_row,
  output logic        o_active,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam bit         HAS_GAP    = (GAP_W > 0);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LOAD   = HAS_GAP ? 8'(GAP_W - 1) : 8'd0;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [11:0] row_q;
  logic        err_q;
  logic        accept;
  logic        code_ok;

  assign o_ready  = (state == S_IDLE) & ~i_clear;
  assign accept   = i_valid & o_ready;
  assign code_ok  = (i_code < 4'd12);

  assign o_row    = row_q;
  assign o_active = |row_q;
  assign o_busy   = (state != S_IDLE);
  assign o_err    = err_q;

  // The accepted code is held directly in one-hot form; row_q doubles as the code register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else if (i_clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (code_ok) begin
              row_q <= 12'd1 << i_code;
              cnt   <= PULSE_LOAD;
              state <= S_PULSE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            row_q <= '0;
            if (HAS_GAP) begin
              cnt   <= GAP_LOAD;
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          row_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_strobe_gen.sv
// Bench for row_strobe_gen: vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a queue-based timeline model.
module tb_row_strobe_gen;

  localparam int PW = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  a_code, b_code;
  logic        a_valid, b_valid, a_clear, b_clear;
  logic        a_ready, b_ready, a_active, b_active, a_busy, b_busy, a_err, b_err;
  logic [11:0] a_row, b_row;

  row_strobe_gen #(.PULSE_W(PW), .GAP_W(GW)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(a_code), .i_valid(a_valid),
    .o_ready(a_ready), .i_clear(a_clear), .o_row(a_row), .o_active(a_active),
    .o_busy(a_busy), .o_err(a_err)
  );

  row_strobe_gen #(.PULSE_W(1), .GAP_W(0)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_code(b_code), .i_valid(b_valid),
    .o_ready(b_ready), .i_clear(b_clear), .o_row(b_row), .o_active(b_active),
    .o_busy(b_busy), .o_err(b_err)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Read-path 12-row priority encoder (highest row wins); returns {match, index}.
  function automatic logic [4:0] enc12(input logic [11:0] r);
    logic [4:0] res;
    res = '0;
    for (int i = 0; i < 12; i++) if (r[i]) res = {1'b1, 4'(i)};
    return res;
  endfunction

  // Timeline model: each accepted code schedules its future row values in a queue.
  logic [11:0] m_q[$];
  logic [11:0] m_row;
  logic        m_err, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_row  = '0;
      m_err  = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_err = 1'b0;
      if (a_clear) begin
        m_q.delete();
      end else if (a_valid && !m_busy) begin
        if (a_code < 4'd12) begin
          for (int i = 0; i < PW; i++) m_q.push_back(12'd1 << a_code);
          for (int i = 0; i < GW; i++) m_q.push_back(12'd0);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_q.size() > 0) begin
        m_row  = m_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_row  = '0;
        m_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic        valid;
    logic [3:0]  code;
    logic        clear;
    logic [11:0] row;
    logic        ready;
    logic        err;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic cl,
                              input logic [11:0] r, input logic rdy, input logic e,
                              input logic b);
    vec_t t;
    t.valid = v; t.code = c; t.clear = cl; t.row = r; t.ready = rdy; t.err = e; t.busy = b;
    return t;
  endfunction

  initial begin
    logic [11:0] one;
    logic [4:0]  ev;
    int          last_acc;
    one = 12'd1;
    last_acc = 0;

    rst_n = 1'b0;
    a_valid = 1'b0; a_code = '0; a_clear = 1'b0;
    b_valid = 1'b0; b_code = '0; b_clear = 1'b0;
    #3;
    chk("rst_row", 32'(a_row), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_active", 32'(a_active), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Invalid codes 12 and 15, then code 3; abort of code 7; clear+valid in IDLE.
    vecs.push_back(mk(1, 4'd12, 0, 12'h000, 1, 0, 0));
    vecs.push_back(mk(1, 4'd15, 0, 12'h000, 1, 1, 0));
    vecs.push_back(mk(1, 4'd3,  0, 12'h000, 1, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 12'h008, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h008, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h008, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h008, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 1, 0, 0));
    vecs.push_back(mk(1, 4'd7,  0, 12'h000, 1, 0, 0));
    vecs.push_back(mk(0, 4'd0,  0, 12'h080, 0, 0, 1));
    vecs.push_back(mk(1, 4'd5,  1, 12'h080, 0, 0, 1));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 1, 0, 0));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 1, 0, 0));
    vecs.push_back(mk(1, 4'd12, 1, 12'h000, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0,  0, 12'h000, 1, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      a_valid = vecs[i].valid; a_code = vecs[i].code; a_clear = vecs[i].clear;
      #1;
      chk($sformatf("vec%0d_row", i), 32'(a_row), 32'(vecs[i].row));
      chk($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_active", i), 32'(a_active), 32'(vecs[i].row != 0));
    end
    @(negedge clk);
    a_valid = 1'b0; a_clear = 1'b0;

    // Round trip: codes 0..11 back-to-back with valid held high.
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      a_valid = 1'b1; a_code = 4'(n);
      #1;
      chk("rt_ready", 32'(a_ready), 32'h1);
      if (n > 0) chk("rt_spacing", 32'(cyc - last_acc), 32'd7);
      last_acc = cyc;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        #1;
        if (k < 4) begin
          chk("rt_row", 32'(a_row), 32'(one << n));
          ev = enc12(a_row);
          chk("rt_enc", 32'(ev), 32'({1'b1, 4'(n)}));
        end else begin
          chk("rt_gap_row", 32'(a_row), 32'h0);
        end
      end
    end
    @(negedge clk);
    a_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a strobe.
    a_valid = 1'b1; a_code = 4'd2;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("ar_pre_row", 32'(a_row), 32'h004);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_row", 32'(a_row), 32'h0);
    chk("ar_busy", 32'(a_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_code = 4'd9;
    #1;
    chk("ar_ready", 32'(a_ready), 32'h1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("ar_row9", 32'(a_row), 32'h200);
    chk("ar_busy9", 32'(a_busy), 32'h1);
    repeat (7) @(negedge clk);

    // PULSE_W=1, GAP_W=0: codes 11 then 0.
    b_valid = 1'b1; b_code = 4'd11;
    #1;
    chk("g0_ready0", 32'(b_ready), 32'h1);
    @(negedge clk);
    b_code = 4'd0;
    #1;
    chk("g0_row11", 32'(b_row), 32'h800);
    chk("g0_ready1", 32'(b_ready), 32'h0);
    chk("g0_busy1", 32'(b_busy), 32'h1);
    @(negedge clk);
    #1;
    chk("g0_row_gap", 32'(b_row), 32'h0);
    chk("g0_ready2", 32'(b_ready), 32'h1);
    chk("g0_busy2", 32'(b_busy), 32'h0);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("g0_row0", 32'(b_row), 32'h001);
    @(negedge clk);
    #1;
    chk("g0_row_end", 32'(b_row), 32'h0);
    chk("g0_ready3", 32'(b_ready), 32'h1);

    // Randomized traffic against the timeline model.
    repeat (1500) begin
      @(negedge clk);
      chk("rnd_row", 32'(a_row), 32'(m_row));
      chk("rnd_err", 32'(a_err), 32'(m_err));
      chk("rnd_busy", 32'(a_busy), 32'(m_busy));
      chk("rnd_active", 32'(a_active), 32'(m_row != 0));
      chk("rnd_onehot", 32'($countones(a_row) <= 1), 32'h1);
      a_valid = 1'($urandom_range(0, 1));
      a_code  = 4'($urandom_range(0, 15));
      a_clear = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_ready", 32'(a_ready), 32'(!m_busy && !a_clear));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/row_strobe_gen.md
# row_strobe_gen

Sequenced 1-of-12 row-strobe generator: accepts a 4-bit binary row code (0..11) over a valid/ready handshake and drives the matching bit of a 12-bit one-hot row bus for a programmable pulse width, followed by a programmable dead gap. It is the inverse of the 12-row priority encoder on the read path. It sits on the write/punch path of the control unit, turning binary row codes into timed row-magnet strobes. Codes 12..15 are rejected with an error pulse.

## Interface
- PULSE_W, default 4: strobe-high duration in clocks; legal range 1..255.
- GAP_W, default 2: dead time after each strobe in clocks; legal range 0..255.
- Timing: one clock; reset is asynchronous and active-low.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_code  input  4  binary row code; bit n of o_row for n = 0..11.
- i_valid  input  1  i_code is presented.
- o_ready  output  1  block accepts i_code this cycle.
- i_clear  input  1  synchronous abort of any strobe or gap in progress.
- o_row  output  12  one-hot row strobe; all zero when not pulsing.
- o_active  output  1  OR of o_row.
- o_busy  output  1  high in PULSE or GAP.
- o_err  output  1  one-cycle pulse when a code of 12..15 is accepted.

## Operation
- Reset values: o_row=0, o_active=0, o_busy=0, o_err=0, state=IDLE, counter=0, code register=0. o_ready=1 once i_reset_n is high and i_clear is low.
- FSM states: IDLE, PULSE, GAP.
- o_ready = (state==IDLE) & ~i_clear. This path is combinational.
- Accept occurs on a clock edge where i_valid & o_ready.
- IDLE, accept, code 0..11:
  - latch the code;
  - load counter with PULSE_W-1;
  - go to PULSE.
- IDLE, accept, code 12..15:
  - stay in IDLE;
  - assert o_err for exactly the next cycle;
  - no strobe is produced.
- PULSE:
  - o_row = 1 << code. o_row is registered, not decoded from i_code.
  - The counter decrements each cycle.
  - At counter 0: if GAP_W>0, load GAP_W-1 and go to GAP; else go to IDLE.
- GAP:
  - o_row = 0.
  - The counter decrements each cycle.
  - At counter 0, go to IDLE.
- i_clear has priority over everything:
  - the next state is IDLE;
  - o_row=0 and o_err=0 from the next edge;
  - no accept happens in a cycle where i_clear is high.
- o_row carries at most one set bit at all times. o_row==0 whenever state != PULSE.
- i_code and i_valid are ignored outside IDLE.
- The counter is 8 bits. Arithmetic never wraps, because loads are always ≥0 and the block exits at 0.

## Timing
- Accept at edge N (code 0..11):
  - o_row is valid from cycle N+1 through N+PULSE_W;
  - o_row is zero from N+PULSE_W+1 through N+PULSE_W+GAP_W;
  - o_ready returns high in cycle N+PULSE_W+GAP_W+1.
- Back-to-back throughput is one code per PULSE_W+GAP_W+1 clocks.
- Invalid code accepted at edge N:
  - o_err is high in cycle N+1 only;
  - o_ready stays high, so a new accept is possible at edge N+1.
- o_busy equals (state != IDLE). o_active equals |o_row. Both are registered-state derived and have no combinational path from inputs.
- Reset asserted mid-PULSE: o_row is zero immediately (asynchronous), not at the next edge. After deassertion the block is in IDLE.
- i_clear high during PULSE at edge M: o_row is zero from M+1, and o_ready is high in cycle M+1 if i_clear is low then.
- i_clear and i_valid in the same IDLE cycle: no accept, no o_err.

## Test plan
- Round trip: defaults, send codes 0..11 back-to-back with i_valid held high.
  - Each code n gives o_row=1<<n for 4 cycles, then 2 zero cycles.
  - Accepts occur every 7 clocks.
  - Feeding o_row into the read-path priority encoder returns n, with match=1.
- Invalid codes: send 12, then 15.
  - Each gives an o_err pulse of 1 cycle, o_row stays 0, and o_ready never drops.
  - Then send 3: o_row=0x008 one cycle after accept.
- GAP_W=0, PULSE_W=1, codes 11 then 0:
  - o_row=0x800 for 1 cycle, then o_ready high for one cycle, then o_row=0x001 for 1 cycle.
- Abort: send code 7, raise i_clear on the 2nd PULSE cycle.
  - o_row=0 on the next cycle and o_busy=0.
  - i_valid with code 5 in the same cycle as i_clear is not accepted.
- Async reset: drop i_reset_n mid-PULSE between clock edges.
  - o_row and o_busy go to 0 before the next edge.
  - After release, code 9 gives o_row=0x200 with normal latency.
